// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: opcodes, state
// encodings, ALU/mux select codes and the bundle of Moore control outputs.
package multi_cycle_ctrl_pkg;

    // Instruction opcodes (IR[31:26])
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    // FSM state encodings, also shown on the debug display
    localparam logic [3:0] S_IF   = 4'd0;
    localparam logic [3:0] S_ID   = 4'd1;
    localparam logic [3:0] S_MADR = 4'd2;
    localparam logic [3:0] S_MRD  = 4'd3;
    localparam logic [3:0] S_MWB  = 4'd4;
    localparam logic [3:0] S_MWR  = 4'd5;
    localparam logic [3:0] S_REXE = 4'd6;
    localparam logic [3:0] S_RWB  = 4'd7;
    localparam logic [3:0] S_BR   = 4'd8;
    localparam logic [3:0] S_JMP  = 4'd9;
    localparam logic [3:0] S_IEXE = 4'd10;
    localparam logic [3:0] S_IWB  = 4'd11;
    localparam logic [3:0] S_TRAP = 4'd15;

    // ALUOp codes
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALUSrcB codes
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    // PCSource codes
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Raw Moore outputs of one state, before step gating
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    // States whose completion retires the current instruction
    function automatic logic is_retire_state(input logic [3:0] s);
        case (s)
            S_MWB, S_MWR, S_RWB, S_IWB, S_BR, S_JMP: is_retire_state = 1'b1;
            default:                                 is_retire_state = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state-to-control decoder: the raw Moore outputs of each state.
module mc_ctrl_decode
    import multi_cycle_ctrl_pkg::*;
(
    input  logic [3:0] state_i,
    input  logic       is_bne_i,
    output ctrl_t      ctrl_o
);

    // Every output defaults to its inactive value; each state raises only its own
    always_comb begin
        ctrl_o           = '0;
        ctrl_o.alu_src_b = SRCB_B;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.pc_source = PCSRC_ALU;
        case (state_i)
            S_IF: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.ir_write  = 1'b1;
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
            end
            S_ID: begin
                ctrl_o.alu_src_b = SRCB_IMMSH2;
            end
            S_MADR, S_IEXE: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
            end
            S_MRD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            S_MWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            S_MWR: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.iord      = 1'b1;
            end
            S_REXE: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
            end
            S_BR: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
                ctrl_o.branch_ne     = is_bne_i;
            end
            S_JMP: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCSRC_JUMP;
            end
            S_IWB: begin
                ctrl_o.reg_write = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control unit: state register, opcode latch, step gating,
// sticky illegal-opcode trap and cycle/retired-instruction counters.
module multi_cycle_ctrl
    import multi_cycle_ctrl_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter bit EN_BNE  = 1'b1,
    parameter bit EN_ADDI = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             step,
    input  logic [5:0]       opcode,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             BranchNE,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic [3:0]       state,
    output logic             instr_done,
    output logic             illegal,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    logic [3:0]       state_q, state_d;
    logic [5:0]       op_q, op_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] ins_q, ins_d;
    logic             retire;
    ctrl_t            ctrl;

    // Dispatch target out of ID; disabled optional opcodes trap like unknown ones
    function automatic logic [3:0] id_target(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW: id_target = S_MADR;
            OP_R:         id_target = S_REXE;
            OP_BEQ:       id_target = S_BR;
            OP_BNE:       id_target = EN_BNE ? S_BR : S_TRAP;
            OP_J:         id_target = S_JMP;
            OP_ADDI:      id_target = EN_ADDI ? S_IEXE : S_TRAP;
            default:      id_target = S_TRAP;
        endcase
    endfunction

    // Next-state logic; nothing moves unless step is high
    always_comb begin
        state_d = state_q;
        if (step) begin
            case (state_q)
                S_IF:    state_d = S_ID;
                S_ID:    state_d = id_target(opcode);
                S_MADR:  state_d = (op_q == OP_LW) ? S_MRD : S_MWR;
                S_MRD:   state_d = S_MWB;
                S_REXE:  state_d = S_RWB;
                S_IEXE:  state_d = S_IWB;
                S_MWB, S_MWR, S_RWB, S_IWB, S_BR, S_JMP: state_d = S_IF;
                S_TRAP:  state_d = S_TRAP;
                default: state_d = S_IF;
            endcase
        end
    end

    // Opcode latch, trap flag and counters
    always_comb begin
        retire    = step && is_retire_state(state_q);
        op_d      = (step && state_q == S_ID) ? opcode : op_q;
        illegal_d = illegal_q | (state_d == S_TRAP);
        cyc_d     = step ? cyc_q + CNT_W'(1) : cyc_q;
        ins_d     = retire ? ins_q + CNT_W'(1) : ins_q;
    end

    // Registered state; reset abandons any in-flight instruction
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IF;
            op_q      <= '0;
            illegal_q <= 1'b0;
            cyc_q     <= '0;
            ins_q     <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
            cyc_q     <= cyc_d;
            ins_q     <= ins_d;
        end
    end

    mc_ctrl_decode u_decode (
        .state_i  (state_q),
        .is_bne_i (op_q == OP_BNE),
        .ctrl_o   (ctrl)
    );

    // Output drive; write enables only fire on stepped cycles
    always_comb begin
        PCWrite     = ctrl.pc_write & step;
        PCWriteCond = ctrl.pc_write_cond & step;
        BranchNE    = ctrl.branch_ne;
        IorD        = ctrl.iord;
        MemRead     = ctrl.mem_read;
        MemWrite    = ctrl.mem_write & step;
        IRWrite     = ctrl.ir_write & step;
        MemtoReg    = ctrl.mem_to_reg;
        RegDst      = ctrl.reg_dst;
        RegWrite    = ctrl.reg_write & step;
        ALUSrcA     = ctrl.alu_src_a;
        ALUSrcB     = ctrl.alu_src_b;
        ALUOp       = ctrl.alu_op;
        PCSource    = ctrl.pc_source;
        state       = state_q;
        instr_done  = retire & ~reset;
        illegal     = illegal_q;
        cycle_count = cyc_q;
        instr_count = ins_q;
    end

endmodule
